// File: rtl/bsg_mcl_axil_pkg.sv
// Shared constants and sizing helpers for the AXI-Lite <-> manycore FIFO bridge.
`ifndef BSG_WIDTH
`define BSG_WIDTH(x) ($clog2((x)+1))
`endif

package bsg_mcl_axil_pkg;

  localparam int unsigned axil_data_width_gp = 32;

  function automatic int unsigned bsg_mcl_axil_ratio(input int unsigned fifo_w,
                                                     input int unsigned axil_w);
    return fifo_w / axil_w;
  endfunction

  // Word-index width; a ratio of 1 still needs a 1-bit counter.
  function automatic int unsigned bsg_mcl_axil_wc_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small 1-read 1-write FIFO with valid/yumi handshake and a free-entry count.
module bsg_fifo_1r1w_small #(
  parameter  int unsigned width_p       = 32,
  parameter  int unsigned els_p         = 2,
  localparam int unsigned free_width_lp = $clog2(els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic [free_width_lp-1:0] free_o
);

  localparam int unsigned ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]       mem_q [els_p];
  logic [ptr_width_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [free_width_lp-1:0] count_q, count_d;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (v_i)    wptr_d = ptr_inc(wptr_q);
    if (yumi_i) rptr_d = ptr_inc(rptr_q);
    case ({v_i, yumi_i})
      2'b10:   count_d = count_q + free_width_lp'(1);
      2'b01:   count_d = count_q - free_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q] <= data_i;
  end

  assign v_o    = (count_q != '0);
  assign data_o = mem_q[rptr_q];
  assign free_o = free_width_lp'(els_p) - count_q;

endmodule

// File: rtl/bsg_mcl_axil_sipo.sv
// Serial-in parallel-out word assembler with optional partial-packet timeout
// (BSG_MCL_AXIL_FIFOS_MASTER_TIMEOUT_EN).
module bsg_mcl_axil_sipo
  import bsg_mcl_axil_pkg::*;
#(
  parameter  int unsigned fifo_width_p      = 128,
  parameter  int unsigned axil_data_width_p = axil_data_width_gp,
  parameter  int unsigned timeout_p         = 1024,
  localparam int unsigned ratio_lp          = bsg_mcl_axil_ratio(fifo_width_p, axil_data_width_p),
  localparam int unsigned wc_width_lp       = bsg_mcl_axil_wc_width(ratio_lp)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [axil_data_width_p-1:0] data_i,
  input  logic                         v_i,
  output logic [fifo_width_p-1:0]      pkt_o,
  output logic                         last_o,
  output logic [wc_width_lp-1:0]       word_count_o,
  output logic                         timeout_o
);

  localparam int unsigned top_lsb_lp = (ratio_lp - 1) * axil_data_width_p;

  logic [wc_width_lp-1:0]  wc_q, wc_d;
  logic [fifo_width_p-1:0] pkt_q;
  logic [fifo_width_p-1:0] pkt_c;
  logic                    last_c;
  logic                    expire_c;

  assign last_c = v_i && (wc_q == wc_width_lp'(ratio_lp - 1));

`ifdef BSG_MCL_AXIL_FIFOS_MASTER_TIMEOUT_EN
  localparam int unsigned idle_width_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;

  logic [idle_width_lp-1:0] idle_q, idle_d;
  logic                     timeout_q;

  assign expire_c = (wc_q != '0) && !v_i && (idle_q == idle_width_lp'(timeout_p - 1));

  always_comb begin
    idle_d = idle_q + idle_width_lp'(1);
    if (v_i || (wc_q == '0) || expire_c) idle_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= expire_c;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign expire_c  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    wc_d = wc_q;
    if (v_i)           wc_d = last_c ? '0 : wc_q + wc_width_lp'(1);
    else if (expire_c) wc_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) wc_q <= '0;
    else            wc_q <= wc_d;
  end

  always_ff @(posedge clk_i) begin
    if (v_i) pkt_q[int'(wc_q) * axil_data_width_p +: axil_data_width_p] <= data_i;
  end

  // The last word bypasses the register so the packet is complete on the accept cycle.
  always_comb begin
    pkt_c = pkt_q;
    pkt_c[top_lsb_lp +: axil_data_width_p] = data_i;
  end

  assign pkt_o        = pkt_c;
  assign last_o       = last_c;
  assign word_count_o = wc_q;

endmodule

// File: rtl/bsg_mcl_axil_fifos_master.sv
// AXI-Lite response words -> packed manycore packets with credit flow control.
// Optional partial-packet timeout: BSG_MCL_AXIL_FIFOS_MASTER_TIMEOUT_EN.
module bsg_mcl_axil_fifos_master
  import bsg_mcl_axil_pkg::*;
#(
  parameter  int unsigned fifo_width_p         = 128,
  parameter  int unsigned rsp_credits_p        = 2,
  parameter  int unsigned axil_data_width_p    = axil_data_width_gp,
  parameter  int unsigned timeout_p            = 1024,
  localparam int unsigned ratio_lp             = bsg_mcl_axil_ratio(fifo_width_p, axil_data_width_p),
  localparam int unsigned rsp_credits_width_lp = `BSG_WIDTH(ratio_lp * rsp_credits_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [axil_data_width_p-1:0]    axil_rsp_i,
  input  logic                            axil_rsp_v_i,
  output logic                            axil_rsp_ready_o,
  output logic [fifo_width_p-1:0]         fifo_rsp_o,
  output logic                            fifo_rsp_v_o,
  input  logic                            fifo_rsp_ready_i,
  output logic [rsp_credits_width_lp-1:0] rsp_credits_o,
  output logic                            timeout_o
);

  localparam int unsigned wc_width_lp   = bsg_mcl_axil_wc_width(ratio_lp);
  localparam int unsigned free_width_lp = `BSG_WIDTH(rsp_credits_p);

  if (ratio_lp * axil_data_width_p != fifo_width_p) begin : g_width_check
    $fatal(1, "fifo_width_p must be a multiple of axil_data_width_p");
  end

  logic                            accept_c;
  logic                            last_c;
  logic [fifo_width_p-1:0]         pkt_c;
  logic [wc_width_lp-1:0]          word_count;
  logic                            fifo_v;
  logic [free_width_lp-1:0]        fifo_free;
  logic [rsp_credits_width_lp-1:0] credits_c;

  // Free word slots: whole free packet entries minus words already staged.
  assign credits_c = rsp_credits_width_lp'(ratio_lp * 32'(fifo_free))
                   - rsp_credits_width_lp'(word_count);

  assign axil_rsp_ready_o = reset_n_i & (credits_c != '0);
  assign accept_c         = axil_rsp_v_i & axil_rsp_ready_o;

  bsg_mcl_axil_sipo #(
    .fifo_width_p      (fifo_width_p),
    .axil_data_width_p (axil_data_width_p),
    .timeout_p         (timeout_p)
  ) u_sipo (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .data_i       (axil_rsp_i),
    .v_i          (accept_c),
    .pkt_o        (pkt_c),
    .last_o       (last_c),
    .word_count_o (word_count),
    .timeout_o    (timeout_o)
  );

  bsg_fifo_1r1w_small #(
    .width_p (fifo_width_p),
    .els_p   (rsp_credits_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (last_c),
    .data_i    (pkt_c),
    .v_o       (fifo_v),
    .data_o    (fifo_rsp_o),
    .yumi_i    (fifo_v & fifo_rsp_ready_i),
    .free_o    (fifo_free)
  );

  assign fifo_rsp_v_o  = fifo_v;
  assign rsp_credits_o = credits_c;

endmodule

// File: tb/tb_bsg_mcl_axil_fifos_master.sv
// Directed + random bench for bsg_mcl_axil_fifos_master against a queue-based model.
module tb_bsg_mcl_axil_fifos_master;

  localparam int unsigned FW = 128;
  localparam int unsigned W  = 32;
  localparam int unsigned NC = 2;
  localparam int unsigned R  = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [W-1:0]  axil_rsp_i = '0;
  logic          axil_rsp_v_i = 1'b0;
  logic          axil_rsp_ready_o;
  logic [FW-1:0] fifo_rsp_o;
  logic          fifo_rsp_v_o;
  logic          fifo_rsp_ready_i = 1'b0;
  logic [3:0]    rsp_credits_o;
  logic          timeout_o;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] pkts  [$];
  logic [W-1:0]  words [$];
  int            idle   = 0;
  logic          exp_to = 1'b0;
  logic [3:0]    obs_credits;
  logic          obs_to;

  always #5 clk = ~clk;

  bsg_mcl_axil_fifos_master #(
    .fifo_width_p      (FW),
    .rsp_credits_p     (NC),
    .axil_data_width_p (W),
    .timeout_p         (TO)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .axil_rsp_i       (axil_rsp_i),
    .axil_rsp_v_i     (axil_rsp_v_i),
    .axil_rsp_ready_o (axil_rsp_ready_o),
    .fifo_rsp_o       (fifo_rsp_o),
    .fifo_rsp_v_o     (fifo_rsp_v_o),
    .fifo_rsp_ready_i (fifo_rsp_ready_i),
    .rsp_credits_o    (rsp_credits_o),
    .timeout_o        (timeout_o)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check model prediction at negedge, advance model at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic [3:0]    ec;
    logic          er, ev, acc, pop;
    logic [FW-1:0] p;
    axil_rsp_v_i     = v;
    axil_rsp_i       = d;
    fifo_rsp_ready_i = r;
    @(negedge clk);
    ec = 4'(int'(R) * (int'(NC) - pkts.size()) - words.size());
    er = (ec != 4'd0);
    ev = (pkts.size() != 0);
    chk("credits", 128'(rsp_credits_o), 128'(ec));
    chk("ready", 128'(axil_rsp_ready_o), 128'(er));
    chk("valid", 128'(fifo_rsp_v_o), 128'(ev));
    if (ev) chk("data", fifo_rsp_o, pkts[0]);
    chk("timeout", 128'(timeout_o), 128'(exp_to));
    obs_credits = rsp_credits_o;
    obs_to      = timeout_o;
    acc = v & er;
    pop = ev & r;
    @(posedge clk);
    if (pop) void'(pkts.pop_front());
    if (acc) begin
      words.push_back(d);
      if (words.size() == int'(R)) begin
        p = '0;
        for (int k = 0; k < int'(R); k++) p[k*W +: W] = words[k];
        pkts.push_back(p);
        words.delete();
      end
    end
    exp_to = 1'b0;
`ifdef BSG_MCL_AXIL_FIFOS_MASTER_TIMEOUT_EN
    if (words.size() != 0 && !acc) begin
      idle++;
      if (idle == int'(TO)) begin
        words.delete();
        idle   = 0;
        exp_to = 1'b1;
      end
    end else begin
      idle = 0;
    end
`endif
    #1;
  endtask

  task automatic apply_reset();
    axil_rsp_v_i     = 1'b0;
    fifo_rsp_ready_i = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 128'(axil_rsp_ready_o), 128'(0));
    chk("rst_valid", 128'(fifo_rsp_v_o), 128'(0));
    chk("rst_credits", 128'(rsp_credits_o), 128'(8));
    chk("rst_timeout", 128'(timeout_o), 128'(0));
    pkts.delete();
    words.delete();
    idle   = 0;
    exp_to = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         min_cr;
    int         to_cnt;
    logic [3:0] cr_after_pop;

    // 1. reset and idle
    #1;
    apply_reset();
    repeat (3) step(1'b0, '0, 1'b0);
    chk("idle_credits", 128'(obs_credits), 128'(8));

    // 2. four directed words, no consumer
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    step(1'b1, 32'h44, 1'b0);
    chk("pkt0_v", 128'(fifo_rsp_v_o), 128'(1));
    chk("pkt0_data", fifo_rsp_o, 128'h00000044_00000033_00000022_00000011);
    chk("pkt0_credits", 128'(rsp_credits_o), 128'(4));

    // 3. fill to zero credits, hold a word, pop one
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0);
    chk("full_credits", 128'(rsp_credits_o), 128'(0));
    chk("full_ready", 128'(axil_rsp_ready_o), 128'(0));
    repeat (2) step(1'b1, 32'h99, 1'b0);
    step(1'b1, 32'h99, 1'b1);
    cr_after_pop = rsp_credits_o;
    chk("pop_credits", 128'(cr_after_pop), 128'(4));
    step(1'b1, 32'h99, 1'b0);

    // 4. streaming with consumer always ready
    repeat (3) step(1'b0, '0, 1'b1);
    min_cr = 8;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, $urandom, 1'b1);
      if (int'(obs_credits) < min_cr) min_cr = int'(obs_credits);
    end
    chk("stream_min_credits", 128'(min_cr >= 4), 128'(1));
    repeat (4) step(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // 5. reset mid-packet
    step(1'b1, 32'hAAAA_0001, 1'b0);
    step(1'b1, 32'hAAAA_0002, 1'b0);
    apply_reset();
    repeat (3) step(1'b0, '0, 1'b1);
    chk("post_rst_credits", 128'(obs_credits), 128'(8));
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0);
    chk("post_rst_pkt", fifo_rsp_o, 128'h000000B3_000000B2_000000B1_000000B0);
    repeat (2) step(1'b0, '0, 1'b1);

    // 6. partial packet then long idle
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
    to_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b0);
      to_cnt += int'(obs_to);
    end
`ifdef BSG_MCL_AXIL_FIFOS_MASTER_TIMEOUT_EN
    chk("timeout_pulses", 128'(to_cnt), 128'(1));
    chk("timeout_credits", 128'(obs_credits), 128'(8));
`else
    chk("timeout_pulses", 128'(to_cnt), 128'(0));
    chk("timeout_credits", 128'(obs_credits), 128'(5));
`endif
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
